// File: rtl/rob_commit_ctrl.sv
// Reorder buffer commit controller: allocates ids in order, collects out-of-order
// writebacks and retires at most one ready head entry per cycle.
module rob_commit_ctrl #(
  parameter int DEPTH = 32,
  parameter int IDW   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy_i,
  input  logic           flush_i,
  input  logic           alloc_en_i,
  input  logic [4:0]     alloc_regaddr_i,
  input  logic [31:0]    alloc_pc_i,
  input  logic [1:0]     alloc_branch_tag_i,
  output logic           alloc_ready_o,
  output logic [IDW-1:0] alloc_id_o,
  input  logic           wb_en_i,
  input  logic [IDW-1:0] wb_id_i,
  input  logic [31:0]    wb_data_i,
  input  logic           wb_cond_i,
  output logic           commit_en_o,
  output logic [4:0]     commit_regaddr_o,
  output logic [IDW-1:0] commit_id_o,
  output logic [31:0]    commit_data_o,
  output logic [31:0]    commit_pc_o,
  output logic [1:0]     commit_branch_tag_o,
  output logic           commit_cond_o,
  output logic           empty_o
);

  localparam logic [IDW:0] FULL_CNT = (IDW+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [IDW-1:0]   head_q, head_d;
  logic [IDW-1:0]   tail_q, tail_d;
  logic [IDW:0]     count_q, count_d;
  logic             commit_en_d;

  logic [4:0]       regaddr_q [DEPTH];
  logic [31:0]      pc_q      [DEPTH];
  logic [1:0]       tag_q     [DEPTH];
  logic [31:0]      data_q    [DEPTH];
  logic             cond_q    [DEPTH];

  logic do_alloc;
  logic do_wb;
  logic do_commit;

  assign alloc_ready_o = (count_q != FULL_CNT);
  assign alloc_id_o    = tail_q;
  assign empty_o       = (count_q == '0);

  assign do_alloc  = alloc_en_i & alloc_ready_o;
  assign do_commit = valid_q[head_q] & ready_q[head_q];
  // The entry being allocated this cycle is not yet valid, so a writeback to it is dropped.
  assign do_wb     = wb_en_i & valid_q[wb_id_i] & ~(do_alloc & (wb_id_i == tail_q));

  always_comb begin
    valid_d     = valid_q;
    ready_d     = ready_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    commit_en_d = 1'b0;
    if (flush_i) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_wb) begin
        ready_d[wb_id_i] = 1'b1;
      end
      if (do_commit) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
        commit_en_d     = 1'b1;
      end
      if (do_alloc) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + 1'b1;
      end
      case ({do_alloc, do_commit})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q             <= '0;
      ready_q             <= '0;
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      commit_en_o         <= 1'b0;
      commit_regaddr_o    <= '0;
      commit_id_o         <= '0;
      commit_data_o       <= '0;
      commit_pc_o         <= '0;
      commit_branch_tag_o <= '0;
      commit_cond_o       <= 1'b0;
    end else if (rdy_i) begin
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      commit_en_o <= commit_en_d;
      if (commit_en_d) begin
        commit_regaddr_o    <= regaddr_q[head_q];
        commit_id_o         <= head_q;
        commit_data_o       <= data_q[head_q];
        commit_pc_o         <= pc_q[head_q];
        commit_branch_tag_o <= tag_q[head_q];
        commit_cond_o       <= cond_q[head_q];
      end
    end
  end

  // Entry payload carries no reset; valid/ready bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (rdy_i && !flush_i) begin
      if (do_alloc) begin
        regaddr_q[tail_q] <= alloc_regaddr_i;
        pc_q[tail_q]      <= alloc_pc_i;
        tag_q[tail_q]     <= alloc_branch_tag_i;
      end
      if (do_wb) begin
        data_q[wb_id_i] <= wb_data_i;
        cond_q[wb_id_i] <= wb_cond_i;
      end
    end
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- In-order retirement controller (reorder buffer) for the out-of-order core.
- Allocates a 5-bit id per dispatched instruction and collects out-of-order CDB writebacks.
- Presents at most one ready head entry per cycle to the commit stage: regaddr, id, data, pc, branch tag, branch condition.
- Clears all state when the commit stage signals a branch mispredict.

Parameters:
- DEPTH, 32, number of entries; must equal 2^IDW.
- IDW, 5, id width; matches the regfile id field.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rdy_i  in  1  global enable; low freezes all state, outputs hold
- flush_i  in  1  mispredict flush from the commit stage (its rst_c)
- alloc_en_i  in  1  dispatch requests an entry
- alloc_regaddr_i  in  5  destination register (0 = no write)
- alloc_pc_i  in  32  recovery pc used if the branch mispredicts
- alloc_branch_tag_i  in  2  00 non-branch, 01 predicted taken, 10 predicted not-taken
- alloc_ready_o  out  1  entry available (comb: count != DEPTH)
- alloc_id_o  out  IDW  id granted (comb: tail pointer)
- wb_en_i  in  1  CDB broadcast valid
- wb_id_i  in  IDW  id being completed
- wb_data_i  in  32  result value
- wb_cond_i  in  1  resolved branch condition (1 = taken)
- commit_en_o  out  1  registered; head entry retired this cycle
- commit_regaddr_o  out  5  registered
- commit_id_o  out  IDW  registered
- commit_data_o  out  32  registered
- commit_pc_o  out  32  registered
- commit_branch_tag_o  out  2  registered
- commit_cond_o  out  1  registered
- empty_o  out  1  comb: count == 0

Behaviour:
- Storage per entry: valid, ready, regaddr, pc, branch_tag, data, cond.
- Pointers: head, tail (IDW bits, natural wrap DEPTH-1 -> 0); count (IDW+1 bits).
- Reset (async): head = tail = count = 0; all valid/ready = 0; every commit_* output = 0.
  - Reset mid-operation discards all entries; no commit occurs on the reset edge.
- rdy_i = 0: no pointer, entry or output register changes. commit_en_o holds its value; the downstream stage is gated by the same rdy.
- Priority per edge with rdy_i = 1: flush > (alloc, writeback, commit applied together).
- Flush:
  - head = tail = count = 0; all valid/ready cleared; commit_en_o = 0.
  - Same-cycle alloc and wb are dropped.
- Alloc (alloc_en_i & alloc_ready_o):
  - Entry[tail] gets valid = 1, ready = 0 and the alloc fields; tail++.
  - alloc_en_i while full: ignored; no state change.
- Writeback (wb_en_i):
  - If entry[wb_id_i].valid: set ready = 1, data = wb_data_i, cond = wb_cond_i.
  - Writeback to an invalid entry is ignored.
  - wb_id_i equal to the tail being allocated the same cycle is ignored, because that entry is not yet valid.
- Commit decision:
  - Uses pre-edge state. If entry[head].valid & ready, then on the edge: commit_* <= entry[head] fields, commit_en_o <= 1, entry[head].valid <= 0, head++.
  - Otherwise commit_en_o <= 0 and the other commit_* outputs are held.
- Latency: wb at edge N -> earliest commit_en_o high after edge N+1. At most one commit per cycle.
- Count: +1 on alloc, -1 on commit, unchanged when both occur.
  - When full, alloc_ready_o = 0 even if a commit occurs that cycle; no bypass.
- Branch handling: branch_tag and cond pass through unchanged. The commit stage compares them and raises flush_i. Entries younger than the mispredicted branch are discarded by that flush.
- Regaddr 0 entries commit normally; write suppression is downstream.

Test Plan:
- Reset then idle:
  - Required: all commit_* = 0, empty_o = 1, alloc_ready_o = 1, alloc_id_o = 0.
- In-order retire:
  - Stimulus: alloc ids 0,1,2 (regaddr 5,6,7); wb in order 2,0,1 with data 0x22,0x00,0x11.
  - Required: commits appear as id0/0x00, then id1/0x11, then id2/0x22, on consecutive cycles once id1 is written.
  - Required: empty_o = 1 at the end.
- Full and wrap:
  - Stimulus: alloc 32 entries.
  - Required: alloc_ready_o = 0 and a 33rd alloc_en_i is ignored.
  - Stimulus: wb id0 and wait for it to commit.
  - Required: alloc_ready_o = 1 and alloc_id_o = 0 (wrapped).
- Mispredict flush:
  - Stimulus: alloc branch (tag 01, pc 0x100) plus 3 younger entries; wb all of them; flush_i pulsed one cycle after the branch commits.
  - Required: younger entries never commit; head = tail = 0; empty_o = 1.
  - Required: a same-cycle alloc during the flush is dropped.
- Stray writeback and stall:
  - Stimulus: wb to unallocated id 9 while empty.
  - Required: no commit occurs.
  - Stimulus: drop rdy_i low while the head is ready.
  - Required: no commit and no pointer change until rdy_i returns high.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges with 4 entries pending.
  - Required: outputs go to 0 immediately, before the next clock edge.
  - Required: after release, alloc_id_o = 0.
